alu_mul_seq: RTL
================

# alu_mul_seq

Multi-cycle unsigned shift-and-add multiplier sequencer that time-shares the single 64-bit ALU. It accepts one multiply request at a time over a valid/ready handshake. It drives the ALU ports with accumulate (add) operations, one per cycle, and returns the low XLEN bits of the product over a second valid/ready handshake. It sits beside the ALU in the execute stage. The parent owns the ALU instance and muxes its inputs to this block while `busy` is high.

## Interface
- `XLEN`, default 64: operand, product and ALU datapath width.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `in_valid`  input  1: request present.
- `in_ready`  output  1: block can accept a request (high only in IDLE).
- `in_a`  input  XLEN: multiplicand.
- `in_b`  input  XLEN: multiplier.
- `out_valid`  output  1: product available (high only in DONE).
- `out_ready`  input  1: consumer takes the product.
- `result`  output  XLEN: low XLEN bits of `in_a * in_b`.
- `busy`  output  1: high in RUN and DONE.
- `alu_a`  output  XLEN: ALU operand a (accumulator).
- `alu_b`  output  XLEN: ALU operand b (shifted multiplicand).
- `alu_op`  output  4: ALU opcode, constant `ALU_ADD` (4'b0000).
- `alu_out`  input  XLEN: ALU result, combinational in the same cycle.

## Operation
- Registers:
  - `acc` (XLEN)
  - `mcand` (XLEN)
  - `mplier` (XLEN)
  - `state` ∈ {IDLE, RUN, DONE}
- Combinational outputs:
  - `alu_a = acc`, `alu_b = mcand`, `alu_op = ALU_ADD` in every state.
  - `result = acc`.
- IDLE:
  - `in_ready=1`.
  - On `in_valid` at a rising edge: `acc<=0`, `mcand<=in_a`, `mplier<=in_b`.
  - Next state is DONE if `in_b==0`, otherwise RUN.
- RUN, once per cycle:
  - If `mplier[0]`: `acc<=alu_out`; else `acc` holds.
  - `mcand<=mcand<<1`, `mplier<=mplier>>1`.
  - Next state is DONE when `(mplier>>1)==0`, otherwise RUN.
- DONE:
  - `out_valid=1`; `acc` and `result` are held stable.
  - On `out_ready` at a rising edge: go to IDLE.
  - A request is never accepted in the same edge as DONE→IDLE.
- Arithmetic:
  - Unsigned, with modulo 2^XLEN wrap; the high product bits are discarded.
  - The low XLEN bits are also correct for two's-complement operands.
- `in_valid`, `in_a` and `in_b` are ignored outside IDLE.
- `out_ready` is ignored outside DONE.
- Reset, asynchronous at any time including mid-RUN:
  - `state=IDLE`, `acc=mcand=mplier=0`.
  - Hence `in_ready=1`, `out_valid=0`, `busy=0`, `result=0`, `alu_a=0`, `alu_b=0`, `alu_op=ALU_ADD`.
  - Any in-flight product is lost and no `out_valid` is produced for it.

## Timing
- Let n = index of the most significant set bit of `in_b` + 1 (1..XLEN); n=0 when `in_b==0`.
- Accept edge at cycle 0.
- RUN occupies cycles 1..n.
- `out_valid` rises in cycle n+1:
  - Latency is n+1 cycles from the accept edge.
  - Minimum 1 cycle (`in_b==0`); maximum XLEN+1 cycles (`in_b[XLEN-1]=1`).
- With `out_ready` tied high, DONE lasts 1 cycle and `in_ready` returns in cycle n+2.
- Throughput is one request per n+2 cycles.
- The ALU is combinational: `alu_out` must be valid in the same cycle as `alu_a`/`alu_b`. There is no ALU pipeline stage.

## Structure
- Shared package `alu_pkg` holds:
  - `XLEN` default constant;
  - `ALU_OP_W=4`;
  - opcode constants, at minimum `ALU_ADD=4'b0000`;
  - the `mul_state_t` enum {IDLE, RUN, DONE}.
- No sub-module: a single FSM with three shift/accumulate registers.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset released, no requests:
  - `in_ready=1`, `out_valid=0`, `busy=0`, `result=0`, `alu_op=4'b0000`.
- `in_a=3`, `in_b=5`, `out_ready=1`:
  - 3 RUN cycles; `out_valid` 4 cycles after accept; `result=15`.
  - `in_ready` high again in cycle 5.
- `in_a=0x1234`, `in_b=0`:
  - `out_valid` 1 cycle after accept, `result=0`, no RUN cycles.
- `in_a=3`, `in_b=1<<63`:
  - 64 RUN cycles; `out_valid` at cycle 65; `result=0x8000_0000_0000_0000` (wrap).
- `in_a=0xFFFF_FFFF_FFFF_FFFF`, `in_b=2`, `out_ready=0` for 10 cycles after `out_valid`, with `in_valid=1` and new operands driven throughout:
  - `result=0xFFFF_FFFF_FFFF_FFFE` stable for all 10 cycles.
  - `in_ready=0` and the new request is not accepted until the cycle after `out_ready` is taken.
- `in_a=7`, `in_b=0xFF`, `rst` pulsed asynchronously in RUN cycle 3:
  - Immediately `busy=0`, `result=0`, `in_ready=1`.
  - No `out_valid` appears for the aborted request.
  - A following `7*2` request yields 14.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and the blocks that time-share
// it: default datapath width, opcode encoding and the multiplier FSM states.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN     = 64;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// ---------------------------------------------------------------------------
// alu_mul_seq_if
// Bundles the multiplier's request/response handshakes and its borrowed ALU
// port.
//   in_valid/in_ready/in_a/in_b   : request channel (parent -> multiplier)
//   out_valid/out_ready/result    : response channel (multiplier -> parent)
//   busy                          : parent routes the ALU to the multiplier
//   alu_a/alu_b/alu_op            : ALU operands driven by the multiplier
//   alu_out                       : combinational ALU result back in
// Modports: slave = the multiplier, master = the parent owning the ALU.
// ---------------------------------------------------------------------------
interface alu_mul_seq_if #(
  parameter int XLEN = alu_pkg::XLEN
);

  logic                          in_valid;
  logic                          in_ready;
  logic [XLEN-1:0]               in_a;
  logic [XLEN-1:0]               in_b;
  logic                          out_valid;
  logic                          out_ready;
  logic [XLEN-1:0]               result;
  logic                          busy;
  logic [XLEN-1:0]               alu_a;
  logic [XLEN-1:0]               alu_b;
  logic [alu_pkg::ALU_OP_W-1:0]  alu_op;
  logic [XLEN-1:0]               alu_out;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, alu_out,
    output in_ready, out_valid, result, busy, alu_a, alu_b, alu_op
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, alu_out,
    input  in_ready, out_valid, result, busy, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Sequential unsigned shift-and-add multiplier that borrows the shared ALU
// for its accumulate step (one ALU add per RUN cycle). Returns the low XLEN
// bits of a*b, which are also correct for two's-complement operands.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_mul_seq_if.slave (request, response, busy, ALU port)
// Latency from accept edge to out_valid is n+1 cycles, where n is the
// position of the multiplier's highest set bit (n=0 for a zero multiplier).
// ---------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic         clk,
  input  logic         rst,
  alu_mul_seq_if.slave bus
);
  import alu_pkg::*;

  mul_state_t      r_state, w_state_next;
  logic [XLEN-1:0] r_acc, w_acc_next;
  logic [XLEN-1:0] r_mcand, w_mcand_next;
  logic [XLEN-1:0] r_mplier, w_mplier_next;
  logic [XLEN-1:0] w_mplier_shr;

  assign w_mplier_shr = r_mplier >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_state  <= w_state_next;
      r_acc    <= w_acc_next;
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_mcand_next  = r_mcand;
    w_mplier_next = r_mplier;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_acc_next    = '0;
          w_mcand_next  = bus.in_a;
          w_mplier_next = bus.in_b;
          // A zero multiplier needs no add steps: the zero accumulator is the answer.
          w_state_next  = (bus.in_b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // The ALU currently sees acc + mcand; keep its sum only for set multiplier bits.
        if (r_mplier[0]) begin
          w_acc_next = bus.alu_out;
        end
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = w_mplier_shr;
        // Stop as soon as no set multiplier bits remain rather than after XLEN steps.
        if (w_mplier_shr == '0) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE first guarantees no accept on the same edge as the handoff.
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == RUN) || (r_state == DONE);
  assign bus.result    = r_acc;
  assign bus.alu_a     = r_acc;
  assign bus.alu_b     = r_mcand;
  assign bus.alu_op    = ALU_ADD;

endmodule
